// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM-side fifo drain: the FSM state encoding
// and the default stream width.
package sdram_pkg;

  localparam int DEFAULT_BUS_WIDTH = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    READ   = ST_READ,
    DRAIN  = ST_DRAIN
  } drain_state_t;

endpackage

// File: rtl/fifo_drain_if.sv
// Fifo read-side handshake plus the downstream valid/ready stream.
// The slave modport is the drain engine; the master modport is its environment.
interface fifo_drain_if
  import sdram_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) ();

  logic                 empty_n;
  logic [BUS_WIDTH-1:0] fifo_data;
  logic                 rd;
  logic [BUS_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  empty_n,
    input  fifo_data,
    input  out_ready,
    output rd,
    output out_data,
    output out_valid
  );

  modport master (
    output empty_n,
    output fifo_data,
    output out_ready,
    input  rd,
    input  out_data,
    input  out_valid
  );

endinterface

// File: rtl/fifo_drain_buf.sv
// Two-entry circular valid/ready buffer decoupling downstream stalls from the
// fifo read handshake.
module fifo_drain_buf
  import sdram_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [BUS_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_valid,
  output logic [1:0]           count
);

  logic [BUS_WIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count_q;
  logic                 do_pop;

  assign do_pop    = pop && (count_q != 2'd0);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign count     = count_q;

  // Push and pop in the same cycle move both pointers and leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !do_pop) begin
        count_q <= count_q + 2'd1;
      end else if (!push && do_pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                !(push && count_q == 2'd2));

endmodule

// File: rtl/fifo_drain.sv
// Read-side consumer of the 1-word clock-crossing fifo: waits for the data
// register to settle, strobes rd once, and forwards the word downstream.
module fifo_drain
  import sdram_pkg::*;
#(
  parameter int BUS_WIDTH     = DEFAULT_BUS_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_drain_if.slave          bus,
  output logic [CNT_WIDTH-1:0] words_read,
  output logic                 busy
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  drain_state_t          state;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [1:0]            buf_count;
  logic                  push;
  logic                  pop;
  logic [BUS_WIDTH-1:0]  buf_data;
  logic                  buf_valid;

  // Strobes come straight from the state register so rd cannot glitch.
  assign push          = (state == READ);
  assign bus.rd        = push;
  assign busy          = (state != IDLE);
  assign pop           = buf_valid && bus.out_ready;
  assign bus.out_data  = buf_data;
  assign bus.out_valid = buf_valid;

  // A new read is only started with a free slot, so the buffer cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      words_read <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.empty_n && buf_count <= 2'd1) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (!bus.empty_n) begin
            state <= IDLE;
          end else if (settle_cnt == '0) begin
            state <= READ;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        READ: begin
          words_read <= words_read + 1'b1;
          state      <= DRAIN;
        end
        DRAIN: begin
          if (!bus.empty_n) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_drain_buf #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .out_data  (buf_data),
    .out_valid (buf_valid),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a 1-word fifo model feeds the DUT and a queue model of
// the output stream is compared against the DUT every cycle.
module tb_fifo_drain;

  localparam int BW     = 16;
  localparam int CNT_W  = 8;
  localparam int SETTLE = 1;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] words_read;
  logic             busy;

  fifo_drain_if #(.BUS_WIDTH(BW)) bus ();

  fifo_drain #(
    .BUS_WIDTH     (BW),
    .SETTLE_CYCLES (SETTLE),
    .CNT_WIDTH     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .words_read (words_read),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Words still to be offered by the fifo writer, with idle gaps before each.
  logic [BW-1:0] src_q [$];
  int            gap_q [$];
  // Expected contents of the output buffer and words accepted downstream.
  logic [BW-1:0] mbuf [$];
  logic [BW-1:0] popped [$];
  int            rd_cyc [$];
  int            rise_cyc [$];

  logic          fifo_has;
  logic          fifo_loaded;
  logic [BW-1:0] fifo_cur;
  int            gap_cnt;
  int            cyc;
  int            stall_cnt;
  int            wcount;
  logic          rd_q;
  logic          ready_q;
  logic          empty_q;
  int            ready_mode = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [BW-1:0] w, input int gap);
    src_q.push_back(w);
    gap_q.push_back(gap);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (src_q.size() == 0 && !fifo_has && mbuf.size() == 0) break;
    end
    #1;
    check_output(name, (i < budget), 1);
  endtask

  // Fifo model, output-stream model and per-cycle comparison, all at negedge.
  initial begin
    fifo_has = 0; fifo_loaded = 0; fifo_cur = '0; gap_cnt = 0; cyc = 0;
    stall_cnt = 0; wcount = 0; rd_q = 0; ready_q = 0; empty_q = 0;
    bus.empty_n = 1'b0; bus.fifo_data = '0; bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mbuf.delete();
        wcount    = 0;
        stall_cnt = 0;
        check_output("reset_rd", bus.rd, 0);
        check_output("reset_out_valid", bus.out_valid, 0);
        check_output("reset_out_data", bus.out_data, 0);
        check_output("reset_words_read", words_read, 0);
        check_output("reset_busy", busy, 0);
      end else begin
        if (mbuf.size() != 0 && ready_q) popped.push_back(mbuf.pop_front());
        if (rd_q) begin
          mbuf.push_back(fifo_cur);
          wcount++;
        end
        check_output("out_valid", bus.out_valid, (mbuf.size() != 0));
        if (mbuf.size() != 0) check_output("out_data", bus.out_data, mbuf[0]);
        check_output("words_read", words_read, 32'(wcount % (1 << CNT_W)));
        if (!empty_q) check_output("busy_idle_when_empty", busy, 0);
        if (rd_q) check_output("busy_after_read", busy, 1);

        if (rd_q) begin
          fifo_has    = 0;
          fifo_loaded = 0;
          bus.empty_n = 1'b0;
          gap_cnt     = 0;
        end else if (fifo_has && !fifo_loaded) begin
          fifo_loaded   = 1;
          bus.fifo_data = fifo_cur;
        end else if (!fifo_has && src_q.size() != 0) begin
          if (gap_cnt >= gap_q[0]) begin
            fifo_cur = src_q.pop_front();
            void'(gap_q.pop_front());
            fifo_has      = 1;
            bus.empty_n   = 1'b1;
            bus.fifo_data = BW'($urandom);
            rise_cyc.push_back(cyc);
          end else begin
            gap_cnt++;
          end
        end

        if (bus.rd) begin
          check_output("rd_word_ready", {fifo_has, fifo_loaded}, 2'b11);
          check_output("rd_single_cycle", rd_q, 0);
          check_output("rd_buffer_room", (mbuf.size() <= 1), 1);
          check_output("busy_in_read", busy, 1);
          rd_cyc.push_back(cyc);
        end

        if (fifo_has && mbuf.size() <= 1 && !bus.rd) stall_cnt++;
        else stall_cnt = 0;
        check_output("rd_progress", (stall_cnt > 6), 0);
        if (stall_cnt > 6) stall_cnt = 0;
      end

      case (ready_mode)
        1:       bus.out_ready = 1'b1;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        3: begin
          bus.out_ready = 1'b1;
          ready_mode    = 0;
        end
        4:       bus.out_ready = bus.rd;
        default: bus.out_ready = 1'b0;
      endcase
      rd_q    = rst_n && bus.rd;
      ready_q = rst_n && bus.out_ready;
      empty_q = bus.empty_n;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BW-1:0] exp_b [5];
    logic [BW-1:0] exp_c [3];
    int            lat;
    int            i;
    exp_b = '{16'hA5A5, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    exp_c = '{16'h0011, 16'h0012, 16'h0013};

    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;

    // Single word held with no downstream ready.
    ready_mode = 0;
    apply_stimulus(16'hA5A5, 0);
    wait_cycles(10);
    check_output("a_rd_count", rd_cyc.size(), 1);
    lat = (rd_cyc.size() > 0 && rise_cyc.size() > 0) ? rd_cyc[0] - rise_cyc[0] : -1;
    check_output("a_rd_latency", lat, 2);
    check_output("a_out_valid", bus.out_valid, 1);
    check_output("a_out_data", bus.out_data, 16'hA5A5);
    check_output("a_words_read", words_read, 1);
    check_output("a_busy", busy, 0);

    // Back-to-back words with the fifo refilled as soon as it is read.
    rd_cyc.delete();
    ready_mode = 1;
    for (int k = 1; k <= 4; k++) apply_stimulus(BW'(k), 0);
    wait_drain("b_drain", 200);
    check_output("b_rd_count", rd_cyc.size(), 4);
    for (int k = 0; k + 1 < rd_cyc.size(); k++)
      check_output("b_rd_spacing", rd_cyc[k+1] - rd_cyc[k], 4);
    check_output("b_popped_count", popped.size(), 5);
    for (int k = 0; k < popped.size() && k < 5; k++)
      check_output("b_popped_order", popped[k], exp_b[k]);
    check_output("b_words_read", words_read, 5);

    // Downstream stall: third word must wait for a free slot.
    popped.delete();
    rd_cyc.delete();
    ready_mode = 0;
    for (int k = 0; k < 3; k++) apply_stimulus(exp_c[k], 0);
    wait_cycles(40);
    check_output("c_rd_count_stalled", rd_cyc.size(), 2);
    check_output("c_out_valid", bus.out_valid, 1);
    check_output("c_out_data", bus.out_data, 16'h0011);
    check_output("c_busy_held", busy, 0);
    ready_mode = 3;
    wait_cycles(20);
    check_output("c_rd_count_released", rd_cyc.size(), 3);
    check_output("c_out_data_after_pop", bus.out_data, 16'h0012);
    ready_mode = 1;
    wait_drain("c_drain", 200);
    check_output("c_popped_count", popped.size(), 3);
    for (int k = 0; k < popped.size() && k < 3; k++)
      check_output("c_popped_order", popped[k], exp_c[k]);

    // Push and pop on the same edge with one word already buffered.
    popped.delete();
    ready_mode = 0;
    apply_stimulus(16'h0021, 0);
    wait_cycles(12);
    check_output("d_out_data_first", bus.out_data, 16'h0021);
    ready_mode = 4;
    apply_stimulus(16'h0022, 0);
    wait_cycles(12);
    check_output("d_popped_count", popped.size(), 1);
    check_output("d_popped_word", (popped.size() > 0) ? popped[0] : 16'hxxxx, 16'h0021);
    check_output("d_out_valid", bus.out_valid, 1);
    check_output("d_out_data_second", bus.out_data, 16'h0022);
    check_output("d_words_read", words_read, 10);
    ready_mode = 1;
    wait_drain("d_drain", 200);

    // Random words, gaps and downstream readiness.
    ready_mode = 2;
    for (int k = 0; k < 200; k++) apply_stimulus(BW'($urandom), int'($urandom_range(0, 3)));
    wait_drain("e_drain", 4000);
    check_output("e_words_read", words_read, 210);

    // Asynchronous reset while rd is high; the pending word is re-read.
    popped.delete();
    ready_mode = 0;
    apply_stimulus(16'h0077, 0);
    for (i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.rd) break;
    end
    check_output("g_rd_seen", bus.rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("g_rd_async", bus.rd, 0);
    check_output("g_out_valid_async", bus.out_valid, 0);
    check_output("g_words_read_async", words_read, 0);
    check_output("g_busy_async", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("g_idle_after_release", busy, 0);
    ready_mode = 1;
    wait_drain("g_drain", 200);
    check_output("g_popped_count", popped.size(), 1);
    check_output("g_popped_word", (popped.size() > 0) ? popped[0] : 16'hxxxx, 16'h0077);
    check_output("g_words_read", words_read, 1);

    // Counter wrap at 2^CNT_W.
    for (int k = 0; k < 254; k++) apply_stimulus(BW'(16'h1000 + k), 0);
    wait_drain("f_drain_fill", 2000);
    check_output("f_words_read_max", words_read, 8'hFF);
    apply_stimulus(16'hBEEF, 0);
    wait_drain("f_drain_wrap", 200);
    check_output("f_words_read_wrap", words_read, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
